// File: rtl/pwm_gen_multi.sv
// rtl/pwm_gen_multi.sv - multi-channel PWM generator, shared prescaled counter, shadowed per-channel config
// Optional complementary dead-band outputs are enabled by defining PWM_GEN_MULTI_DEADTIME_EN.
module pwm_gen_multi #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef PWM_GEN_MULTI_DEADTIME_EN
   input  logic [7:0]              dead_time,
   output logic [NUM_CH-1:0]       pwm_out_n,
`endif
   input  logic                    pwm_en,
   input  logic [7:0]              prescale,
   input  logic [CNT_W-1:0]        period,
   input  logic                    cfg_wr,
   input  logic [2*NUM_CH-1:0]     ch_mode,
   input  logic [CNT_W*NUM_CH-1:0] cmp1,
   input  logic [CNT_W*NUM_CH-1:0] cmp2,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic [CNT_W-1:0]        count_val,
   output logic                    period_tick,
   output logic                    cfg_pending
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [7:0]              presc_q, presc_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    pending_q, pending_d;
   logic [CNT_W-1:0]        sh_period_q, sh_period_d, act_period_q, act_period_d;
   logic [2*NUM_CH-1:0]     sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
   logic [CNT_W*NUM_CH-1:0] sh_cmp1_q, sh_cmp1_d, act_cmp1_q, act_cmp1_d;
   logic [CNT_W*NUM_CH-1:0] sh_cmp2_q, sh_cmp2_d, act_cmp2_q, act_cmp2_d;
   logic [NUM_CH-1:0]       pwm_q, pwm_d;
   logic [NUM_CH-1:0]       raw;
   logic                    tick;
   logic                    wrap;

   function automatic logic raw_level(input logic [1:0] mode, input logic [CNT_W-1:0] c,
                                      input logic [CNT_W-1:0] lo, input logic [CNT_W-1:0] hi);
      case (mode)
         2'b00:   return c < lo;
         2'b01:   return c >= lo;
         2'b10:   return (lo < hi) && (c >= lo) && (c < hi);
         default: return 1'b0;
      endcase
   endfunction

   // A prescale lowered below the running count still fires immediately.
   assign tick = (presc_q >= prescale);
   assign wrap = pwm_en && tick && (count_q == act_period_q);

   always_comb begin
      presc_d      = presc_q;
      count_d      = count_q;
      pending_d    = pending_q;
      sh_period_d  = sh_period_q;
      sh_mode_d    = sh_mode_q;
      sh_cmp1_d    = sh_cmp1_q;
      sh_cmp2_d    = sh_cmp2_q;
      act_period_d = act_period_q;
      act_mode_d   = act_mode_q;
      act_cmp1_d   = act_cmp1_q;
      act_cmp2_d   = act_cmp2_q;

      if (!pwm_en) begin
         presc_d = '0;
         count_d = '0;
      end else if (tick) begin
         presc_d = '0;
         count_d = wrap ? '0 : count_q + CNT_ONE;
      end else begin
         presc_d = presc_q + 8'd1;
      end

      // A write landing on the wrap cycle bypasses the shadow so it is never a period late.
      if (cfg_wr) begin
         sh_period_d = period;
         sh_mode_d   = ch_mode;
         sh_cmp1_d   = cmp1;
         sh_cmp2_d   = cmp2;
         if (wrap) begin
            act_period_d = period;
            act_mode_d   = ch_mode;
            act_cmp1_d   = cmp1;
            act_cmp2_d   = cmp2;
            pending_d    = 1'b0;
         end else begin
            pending_d    = 1'b1;
         end
      end else if (pending_q && (wrap || !pwm_en)) begin
         act_period_d = sh_period_q;
         act_mode_d   = sh_mode_q;
         act_cmp1_d   = sh_cmp1_q;
         act_cmp2_d   = sh_cmp2_q;
         pending_d    = 1'b0;
      end
   end

   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         raw[i] = raw_level(act_mode_q[2*i +: 2], count_q,
                            act_cmp1_q[CNT_W*i +: CNT_W], act_cmp2_q[CNT_W*i +: CNT_W]);
      end
   end

`ifdef PWM_GEN_MULTI_DEADTIME_EN
   logic [NUM_CH-1:0] pwm_n_q, pwm_n_d;
   logic [NUM_CH-1:0] r_prev_q, r_prev_d;
   logic [7:0]        dc_q [NUM_CH];
   logic [7:0]        dc_d [NUM_CH];

   // Outputs follow the post-decrement count so dead_time=0 gives a gapless complement.
   always_comb begin
      pwm_d    = '0;
      pwm_n_d  = '0;
      r_prev_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         dc_d[i] = 8'd0;
         if (pwm_en) begin
            if (raw[i] != r_prev_q[i]) begin
               dc_d[i] = dead_time;
            end else if (dc_q[i] != 8'd0) begin
               dc_d[i] = dc_q[i] - 8'd1;
            end
            pwm_d[i]    = (dc_d[i] == 8'd0) &&  raw[i];
            pwm_n_d[i]  = (dc_d[i] == 8'd0) && !raw[i];
            r_prev_d[i] = raw[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_n_q  <= '0;
         r_prev_q <= '0;
         for (int i = 0; i < NUM_CH; i++) dc_q[i] <= 8'd0;
      end else begin
         pwm_n_q  <= pwm_n_d;
         r_prev_q <= r_prev_d;
         for (int i = 0; i < NUM_CH; i++) dc_q[i] <= dc_d[i];
      end
   end

   assign pwm_out_n = pwm_n_q;
`else
   assign pwm_d = pwm_en ? raw : '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         count_q      <= '0;
         pending_q    <= 1'b0;
         sh_period_q  <= '0;
         sh_mode_q    <= '0;
         sh_cmp1_q    <= '0;
         sh_cmp2_q    <= '0;
         act_period_q <= '0;
         act_mode_q   <= '0;
         act_cmp1_q   <= '0;
         act_cmp2_q   <= '0;
         pwm_q        <= '0;
      end else begin
         presc_q      <= presc_d;
         count_q      <= count_d;
         pending_q    <= pending_d;
         sh_period_q  <= sh_period_d;
         sh_mode_q    <= sh_mode_d;
         sh_cmp1_q    <= sh_cmp1_d;
         sh_cmp2_q    <= sh_cmp2_d;
         act_period_q <= act_period_d;
         act_mode_q   <= act_mode_d;
         act_cmp1_q   <= act_cmp1_d;
         act_cmp2_q   <= act_cmp2_d;
         pwm_q        <= pwm_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign count_val   = count_q;
   assign cfg_pending = pending_q;
   assign period_tick = wrap && !rst;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// tb/tb_pwm_gen_multi.sv - directed self-checking bench for pwm_gen_multi (NUM_CH=2, CNT_W=8)
module tb_pwm_gen_multi;

   logic        clk = 1'b0;
   logic        rst, pwm_en, cfg_wr;
   logic [7:0]  prescale, period;
   logic [3:0]  ch_mode;
   logic [15:0] cmp1, cmp2;
   logic [1:0]  pwm_out;
   logic [7:0]  count_val;
   logic        period_tick, cfg_pending;
`ifdef PWM_GEN_MULTI_DEADTIME_EN
   logic [7:0]  dead_time;
   logic [1:0]  pwm_out_n;
`endif

   int errors = 0;
   int checks = 0;
   int k = 0;
   int c, th, hi0, nticks;

   always #5 clk = ~clk;

   pwm_gen_multi #(.NUM_CH(2), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
`ifdef PWM_GEN_MULTI_DEADTIME_EN
      .dead_time(dead_time),
      .pwm_out_n(pwm_out_n),
`endif
      .pwm_en(pwm_en),
      .prescale(prescale),
      .period(period),
      .cfg_wr(cfg_wr),
      .ch_mode(ch_mode),
      .cmp1(cmp1),
      .cmp2(cmp2),
      .pwm_out(pwm_out),
      .count_val(count_val),
      .period_tick(period_tick),
      .cfg_pending(cfg_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Disable, write config, let it commit while disabled, then enable with k=0.
   task automatic load(input logic [7:0] per, input logic [7:0] pre, input logic [3:0] mode,
                       input logic [15:0] c1, input logic [15:0] c2);
      pwm_en   = 1'b0;
      period   = per;
      prescale = pre;
      ch_mode  = mode;
      cmp1     = c1;
      cmp2     = c2;
      cfg_wr   = 1'b1;
      step();
      chk("load_pending_set", cfg_pending, 1);
      chk("disabled_count", count_val, 0);
      chk("disabled_pwm", pwm_out, 0);
      cfg_wr = 1'b0;
      step();
      chk("load_commit_disabled", cfg_pending, 0);
      chk("disabled_tick", period_tick, 0);
      pwm_en = 1'b1;
      k = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; pwm_en = 1'b0; cfg_wr = 1'b0; prescale = 8'd0; period = 8'd0;
      ch_mode = 4'd0; cmp1 = 16'd0; cmp2 = 16'd0;
`ifdef PWM_GEN_MULTI_DEADTIME_EN
      dead_time = 8'd0;
`endif
      step();
      step();
      chk("reset_count", count_val, 0);
      chk("reset_pwm", pwm_out, 0);
      chk("reset_tick", period_tick, 0);
      chk("reset_pending", cfg_pending, 0);
      rst = 1'b0;

      // T1: ch0 mode00 cmp1=3, ch1 mode01 cmp1=3, period 9, prescale 0
      load(8'd9, 8'd0, 4'b0100, {8'd3, 8'd3}, 16'd0);
      hi0 = 0;
      for (int j = 0; j < 20; j++) begin
         step();
         c = (k - 1) % 10;
         chk("t1_count", count_val, k % 10);
         chk("t1_pwm", pwm_out, {c >= 3, c < 3});
         chk("t1_tick", period_tick, (k % 10) == 9);
         if (pwm_out[0]) hi0++;
      end
      chk("t1_ch0_high_cycles", hi0, 6);

      // T2: prescale 3, period 4 -> step every 4 clk, wrap every 20 clk
      load(8'd4, 8'd3, 4'b0100, {8'd3, 8'd3}, 16'd0);
      nticks = 0;
      for (int j = 0; j < 40; j++) begin
         step();
         chk("t2_count", count_val, (k / 4) % 5);
         chk("t2_tick", period_tick, ((k % 4) == 3) && (((k / 4) % 5) == 4));
         if (period_tick) nticks++;
      end
      chk("t2_tick_total", nticks, 2);

      // T3: window 2..6 on ch0, inverted window 6..2 on ch1 (constant 0)
      load(8'd9, 8'd0, 4'b1010, {8'd6, 8'd2}, {8'd2, 8'd6});
      for (int j = 0; j < 20; j++) begin
         step();
         c = (k - 1) % 10;
         chk("t3_window", pwm_out, {1'b0, (c >= 2) && (c < 6)});
      end

      // T4: mid-period cfg_wr at c=5 changes cmp1 3->7, applies after the wrap
      load(8'd9, 8'd0, 4'b0100, {8'd3, 8'd3}, 16'd0);
      for (int j = 0; j < 20; j++) begin
         if (k == 5) begin
            cmp1   = {8'd7, 8'd7};
            cfg_wr = 1'b1;
         end else begin
            cfg_wr = 1'b0;
         end
         step();
         c  = (k - 1) % 10;
         th = (k <= 10) ? 3 : 7;
         chk("t4_pwm", pwm_out, {c >= th, c < th});
         if (k == 6 || k == 9) chk("t4_pending_held", cfg_pending, 1);
         if (k == 10) chk("t4_pending_cleared", cfg_pending, 0);
      end
      cfg_wr = 1'b0;

      // T5: cfg_wr exactly on the wrap cycle -> bypass straight to active
      cmp1 = {8'd2, 8'd2};
      for (int j = 0; j < 20; j++) begin
         cfg_wr = (k == 29);
         step();
         c  = (k - 1) % 10;
         th = (k <= 30) ? 7 : 2;
         chk("t5_pwm", pwm_out, {c >= th, c < th});
         if (k == 30) begin
            chk("t5_bypass_pending", cfg_pending, 0);
            chk("t5_wrap_count", count_val, 0);
         end
      end
      cfg_wr = 1'b0;

      // T7: cmp1 beyond period in mode00 is constant high; reserved mode is 0
      load(8'd9, 8'd0, 4'b1100, {8'd5, 8'd12}, {8'd9, 8'd0});
      for (int j = 0; j < 10; j++) begin
         step();
         chk("t7_const", pwm_out, 2'b01);
      end

      // T8: period 0 with prescale 1 -> count held at 0, tick on every prescaler tick
      load(8'd0, 8'd1, 4'b0100, {8'd3, 8'd3}, 16'd0);
      for (int j = 0; j < 6; j++) begin
         step();
         chk("t8_count", count_val, 0);
         chk("t8_tick", period_tick, (k % 2) == 1);
         chk("t8_pwm", pwm_out, 2'b01);
      end

      // T9: reset mid-period with a pending write discards everything
      load(8'd9, 8'd0, 4'b0100, {8'd3, 8'd3}, 16'd0);
      step(); step(); step();
      cmp1   = {8'd5, 8'd5};
      cfg_wr = 1'b1;
      step();
      cfg_wr = 1'b0;
      chk("t9_pending_before_rst", cfg_pending, 1);
      chk("t9_count_before_rst", count_val, 4);
      rst = 1'b1;
      step();
      chk("t9_rst_count", count_val, 0);
      chk("t9_rst_pwm", pwm_out, 0);
      chk("t9_rst_pending", cfg_pending, 0);
      chk("t9_rst_tick", period_tick, 0);
      rst = 1'b0;
      step(); step(); step();
      chk("t9_cleared_period_count", count_val, 0);
      chk("t9_cleared_cfg_pwm", pwm_out, 0);
      chk("t9_cleared_period_tick", period_tick, 1);

`ifdef PWM_GEN_MULTI_DEADTIME_EN
      // T6: dead_time 2, mode00 cmp1=5, period 9 -> 2-clk both-low gaps at each edge
      dead_time = 8'd2;
      load(8'd9, 8'd0, 4'b0000, {8'd5, 8'd5}, 16'd0);
      for (int j = 0; j < 20; j++) begin
         step();
         c = (k - 1) % 10;
         chk("t6_out", pwm_out, ((c >= 2) && (c <= 4)) ? 2'b11 : 2'b00);
         chk("t6_out_n", pwm_out_n, (c >= 7) ? 2'b11 : 2'b00);
         chk("t6_no_overlap", pwm_out & pwm_out_n, 0);
      end
      step(); step();
      rst = 1'b1;
      step();
      chk("t6_rst_out", pwm_out, 0);
      chk("t6_rst_out_n", pwm_out_n, 0);
      rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
